// File: rtl/col_coeff_writer_pkg.sv
// ---------------------------------------------------------------------------
// col_coeff_writer_pkg
//   Shared constants and types for the column coefficient writer.
//   LENGTH  : coefficients per output row (matches the lifting stage)
//   ROWS    : output rows per frame
//   ADDR_W  : coefficient memory address width
//   HI_BASE : base address of the high band (low band starts at 0)
//   DATA_W  : coefficient width
//   wr_state_t : writer FSM state encoding
// ---------------------------------------------------------------------------
package col_coeff_writer_pkg;

    localparam int LENGTH  = 256;
    localparam int ROWS    = 128;
    localparam int ADDR_W  = 16;
    localparam int HI_BASE = ROWS * LENGTH;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } wr_state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/col_coeff_writer_if.sv
// ---------------------------------------------------------------------------
// col_coeff_writer_if
//   Bundles the coefficient-pair stream from the lifting stage with the
//   single-port coefficient memory write bus.
//   Signals:
//     in_valid, s_in, d_in        coefficient pair from the lifting stage
//     mem_we, mem_addr, mem_wdata memory write port
//   Modports:
//     master : the writer (consumes the pair stream, drives the memory bus)
//     slave  : the surroundings (produce the pair stream, observe the bus)
// ---------------------------------------------------------------------------
interface col_coeff_writer_if
    import col_coeff_writer_pkg::*;
#(
    parameter int ADDR_W = col_coeff_writer_pkg::ADDR_W
);

    logic              in_valid;
    logic [DATA_W-1:0] s_in;
    logic [DATA_W-1:0] d_in;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  in_valid,
        input  s_in,
        input  d_in,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output s_in,
        output d_in,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/col_coeff_writer_coeff_fifo.sv
// ---------------------------------------------------------------------------
// col_coeff_writer_coeff_fifo
//   Synchronous show-ahead FIFO holding the high-pass coefficients of one
//   row until the low-pass stream has finished.
//   Ports:
//     clk, resetn   clock, asynchronous active-low reset
//     push, wdata   write one entry (ignored when full)
//     pop           discard the head entry (ignored when empty)
//     flush         empty the FIFO; takes priority over push/pop
//     rdata         head entry, valid whenever empty is low
//     empty, full   status
//     count         number of stored entries
// ---------------------------------------------------------------------------
module col_coeff_writer_coeff_fifo
    import col_coeff_writer_pkg::*;
#(
    parameter int DEPTH = col_coeff_writer_pkg::LENGTH,
    parameter int WIDTH = col_coeff_writer_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = store[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; contents are only visible through valid entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // The writer never pushes more than one row, so a full push is a design bug.
    push_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(push && full && !flush));

endmodule

// File: rtl/col_coeff_writer.sv
// ---------------------------------------------------------------------------
// col_coeff_writer
//   Takes the (s, d) coefficient pairs produced by the column-lifting stage
//   and writes them to the single-port coefficient memory. Low-pass s values
//   are written as they arrive; high-pass d values are parked in a FIFO and
//   written back-to-back once the row's s stream ends. Tracks the row index
//   across a frame and reports row/frame completion.
//
//   Ports:
//     clk, resetn   clock, asynchronous active-low reset
//     start         one-cycle pulse: begin frame, clear row index and overflow
//     bus           col_coeff_writer_if.master: pair stream in, memory bus out
//     busy          high while a row is being streamed or drained
//     row_done      one-cycle pulse after the last write of a row
//     frame_done    one-cycle pulse after the last row of the frame
//     overflow      sticky: a pair arrived when it could not be accepted
//     wr_count      (COL_WRITER_WRCOUNT_EN only) saturating count of writes
//
//   Build option: define COL_WRITER_WRCOUNT_EN to add the wr_count output.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no frame active, in_valid ignored
//   ST_WAIT   | frame active, waiting for the first pair of a row
//   ST_STREAM | accepting pairs, writing s values, buffering d values
//   ST_DRAIN  | writing buffered d values, then closing the row
// ---------------------------------------------------------------------------
module col_coeff_writer
    import col_coeff_writer_pkg::*;
#(
    parameter int LENGTH  = col_coeff_writer_pkg::LENGTH,
    parameter int ROWS    = col_coeff_writer_pkg::ROWS,
    parameter int ADDR_W  = col_coeff_writer_pkg::ADDR_W,
    parameter int HI_BASE = ROWS * LENGTH
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    col_coeff_writer_if.master  bus,
    output logic                busy,
    output logic                row_done,
    output logic                frame_done,
    output logic                overflow
`ifdef COL_WRITER_WRCOUNT_EN
    ,
    output logic [2*ADDR_W-1:0] wr_count
`endif
);

    localparam int JW = $clog2(LENGTH + 1);
    localparam int RW = clog2_min1(ROWS);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_WAIT   = ST_WAIT;
    localparam logic [1:0] S_STREAM = ST_STREAM;
    localparam logic [1:0] S_DRAIN  = ST_DRAIN;

    localparam logic [ADDR_W-1:0] HI_A  = ADDR_W'(HI_BASE);
    localparam logic [ADDR_W-1:0] LEN_A = ADDR_W'(LENGTH);

    logic [1:0]        state;
    logic [RW-1:0]     r;
    logic [ADDR_W-1:0] row_base;   // r*LENGTH, kept as a running sum
    logic [JW-1:0]     j;          // pairs accepted in the current row
    logic [JW-1:0]     k;          // d values written in the current row

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_rdata;
    logic [JW-1:0]     fifo_count;

    logic              in_row;
    logic              room;
    logic              accept;
    logic              drop;
    logic              drain_pop;
    logic              row_end;

    assign in_row = (state == S_WAIT) || (state == S_STREAM);
    assign room   = (j != JW'(LENGTH)) && !fifo_full;

    // start wins over everything else in the cycle it is seen.
    assign accept = !start && bus.in_valid && in_row && room;
    assign drop   = !start && bus.in_valid &&
                    ((state == S_DRAIN) || (in_row && !room));

    // The first d write is issued in the same cycle the s stream is seen to
    // stop, so a short row drains with no idle gap after its last s write.
    assign drain_pop = !start && !fifo_empty &&
                       ((state == S_DRAIN) || ((state == S_STREAM) && !accept));
    assign row_end   = !start && (state == S_DRAIN) && fifo_empty;

    assign busy = (state == S_STREAM) || (state == S_DRAIN) || row_done || accept;

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    col_coeff_writer_coeff_fifo #(
        .DEPTH (LENGTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (drain_pop),
        .flush  (start),
        .wdata  (bus.d_in),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            r           <= '0;
            row_base    <= '0;
            j           <= '0;
            k           <= '0;
            overflow    <= 1'b0;
            row_done    <= 1'b0;
            frame_done  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q   <= 1'b0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;

            if (start) begin
                // Also aborts a row in flight; the FIFO is flushed alongside.
                state    <= S_WAIT;
                r        <= '0;
                row_base <= '0;
                j        <= '0;
                k        <= '0;
                overflow <= 1'b0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                end

                if (accept) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= row_base + ADDR_W'(j);
                    mem_wdata_q <= bus.s_in;
                    j           <= j + JW'(1);
                    state       <= (j == JW'(LENGTH - 1)) ? S_DRAIN : S_STREAM;
                end else if (drain_pop) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= row_base + HI_A + ADDR_W'(k);
                    mem_wdata_q <= fifo_rdata;
                    k           <= k + JW'(1);
                    state       <= S_DRAIN;
                end else if (state == S_STREAM) begin
                    state <= S_DRAIN;
                end else if (row_end) begin
                    row_done <= 1'b1;
                    j        <= '0;
                    k        <= '0;
                    if (r == RW'(ROWS - 1)) begin
                        frame_done <= 1'b1;
                        r          <= '0;
                        row_base   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        r        <= r + RW'(1);
                        row_base <= row_base + LEN_A;
                        state    <= S_WAIT;
                    end
                end
            end
        end
    end

`ifdef COL_WRITER_WRCOUNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count <= '0;
        end else if (start) begin
            wr_count <= '0;
        end else if (mem_we_q && (wr_count != '1)) begin
            wr_count <= wr_count + (2*ADDR_W)'(1);
        end
    end
`endif

    // Buffered d values always equal pairs accepted minus d values written.
    fifo_tracks_row: assert property (@(posedge clk) disable iff (!resetn)
        ((state == S_STREAM) || (state == S_DRAIN)) |-> (fifo_count == j - k));

endmodule

// File: tb/tb_col_coeff_writer.sv
module tb_col_coeff_writer;
    import col_coeff_writer_pkg::*;

    localparam int LEN = 4;
    localparam int NR  = 2;
    localparam int HB  = 8;
    localparam int AW  = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic start  = 1'b0;
    logic busy;
    logic row_done;
    logic frame_done;
    logic overflow;
`ifdef COL_WRITER_WRCOUNT_EN
    logic [2*AW-1:0] wr_count;
`endif

    col_coeff_writer_if #(.ADDR_W(AW)) bus ();

    col_coeff_writer #(
        .LENGTH  (LEN),
        .ROWS    (NR),
        .ADDR_W  (AW),
        .HI_BASE (HB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .row_done   (row_done),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef COL_WRITER_WRCOUNT_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic void exp_wr(input int c, input int a, input int d);
        wr_t e;
        e.cyc  = c;
        e.addr = AW'(a);
        e.data = 8'(d);
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every memory write must match the head of the queue, in
    // the cycle it was predicted for; a predicted write that never shows is
    // reported as missing.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d, no write required",
                         cyc, bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.addr !== bus.mem_addr || e.data !== bus.mem_wdata) begin
                    failures++;
                    $display("FAIL mem_write got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                             cyc, bus.mem_addr, bus.mem_wdata, e.cyc, e.addr, e.data);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missing_write cyc=%0d, required addr=%0d data=%0d at cyc=%0d",
                     cyc, e.addr, e.data, e.cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives one row of n pairs starting in the current cycle t, predicts all
    // writes, and checks busy/row_done/frame_done every cycle up to t+2n+2.
    // glitch >= 0 pulses in_valid at cycle t+glitch (must fall in the drain).
    task automatic run_row(input int s0, input int d0, input int n, input int row,
                           input bit last, input int glitch);
        int  t;
        bit  exp_busy;
        bit  exp_rd;
        bit  exp_fd;
        t = cyc;
        for (int i = 0; i < n; i++) exp_wr(t + 1 + i, row * LEN + i, s0 + i);
        for (int i = 0; i < n; i++) exp_wr(t + n + 1 + i, HB + row * LEN + i, d0 + i);
        for (int c = 0; c <= 2 * n + 2; c++) begin
            bus.in_valid = (c < n) || (c == glitch);
            bus.s_in     = (c < n) ? 8'(s0 + c) : 8'hEE;
            bus.d_in     = (c < n) ? 8'(d0 + c) : 8'hEE;
            @(negedge clk);
            exp_busy = (c <= 2 * n + 1);
            exp_rd   = (c == 2 * n + 1);
            exp_fd   = exp_rd && last;
            checks += 3;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy row=%0d c=%0d got=%b required=%b", row, c, busy, exp_busy);
            end
            if (row_done !== exp_rd) begin
                failures++;
                $display("FAIL row_done row=%0d c=%0d got=%b required=%b", row, c, row_done, exp_rd);
            end
            if (frame_done !== exp_fd) begin
                failures++;
                $display("FAIL frame_done row=%0d c=%0d got=%b required=%b", row, c, frame_done, exp_fd);
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
            busy !== 1'b0 || row_done !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s outputs got we=%b addr=%0d wdata=%0d busy=%b rd=%b fd=%b ovf=%b, required all 0",
                     tag, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, row_done, frame_done, overflow);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        @(negedge clk);
        check_all_zero("reset");
        checks++;
        if (dut.state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d required=0", dut.state);
        end
        step();
        resetn = 1'b1;
        step();
        // in_valid in idle is ignored: no write, no overflow, not busy
        bus.in_valid = 1'b1;
        bus.s_in     = 8'h55;
        bus.d_in     = 8'h66;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (overflow !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignore c=%0d got ovf=%b busy=%b required 0 0", c, overflow, busy);
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        pulse_start();
        run_row(10, 20, 4, 0, 1'b0, -1);
        run_row(30, 40, 4, 1, 1'b1, -1);
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd0 || dut.r !== '0) begin
            failures++;
            $display("FAIL frame_end got state=%0d r=%0d required state=0 r=0", dut.state, dut.r);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL frame_overflow got=%b required=0", overflow);
        end
`ifdef COL_WRITER_WRCOUNT_EN
        checks++;
        if (wr_count !== 32'd16) begin
            failures++;
            $display("FAIL wr_count_frame got=%0d required=16", wr_count);
        end
        step();
        pulse_start();
        @(negedge clk);
        checks++;
        if (wr_count !== 32'd0) begin
            failures++;
            $display("FAIL wr_count_clear got=%0d required=0", wr_count);
        end
`endif
        step();
    endtask

    task automatic test_short_row();
        pulse_start();
        run_row(70, 80, 2, 0, 1'b0, -1);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL short_overflow got=%b required=0", overflow);
        end
        step();
    endtask

    task automatic test_overflow();
        pulse_start();
        run_row(50, 60, 4, 0, 1'b0, 6);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL drain_overflow got=%b required=1", overflow);
        end
        step();
        pulse_start();
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got=%b required=0", overflow);
        end
        step();
    endtask

    task automatic test_abort();
        int t;
        pulse_start();
        t = cyc;
        exp_wr(t + 1, 0, 90);
        exp_wr(t + 2, 1, 91);
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.s_in     = 8'(90 + c);
            bus.d_in     = 8'(92 + c);
            step();
        end
        bus.in_valid = 1'b0;
        pulse_start();
        for (int c = 0; c < 6; c++) step();
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got state=%0d busy=%b required state=1 busy=0", dut.state, busy);
        end
        step();
        run_row(100, 110, 4, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_drain();
        int t;
        pulse_start();
        t = cyc;
        for (int i = 0; i < 4; i++) exp_wr(t + 1 + i, i, 120 + i);
        exp_wr(t + 5, HB, 130);
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.s_in     = 8'(120 + c);
            bus.d_in     = 8'(130 + c);
            step();
        end
        bus.in_valid = 1'b1;   // cycle t+4 is in the drain: sets overflow
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_overflow got=%b required=1", overflow);
        end
        step();
        resetn = 1'b0;
        #1;
        check_all_zero("mid_drain_reset");
        @(negedge clk);
        check_all_zero("mid_drain_reset_hold");
        step();
        step();
        resetn = 1'b1;
        step();
        pulse_start();
        run_row(1, 2, 4, 0, 1'b0, -1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.s_in     = '0;
        bus.d_in     = '0;
        test_reset();
        test_full_frame();
        test_short_row();
        test_overflow();
        test_abort();
        test_reset_mid_drain();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/col_coeff_writer.md
Name: col_coeff_writer

Overview:
- Downstream neighbour of the column-lifting stage. Consumes its per-cycle coefficient pair (s, d, result) and writes them to the single-port coefficient memory.
- Low-pass s values go out immediately. High-pass d values are buffered and drained after each row, because the memory port takes one word per cycle.
- Tracks the output row index across a frame and reports row/frame completion to the top-level controller.

Parameters:
- LENGTH, 256, coefficients per output row; must match the lifting stage; ≤ 511.
- ROWS, 128, output rows per frame.
- ADDR_W, 16, memory address width; must satisfy 2*ROWS*LENGTH ≤ 2^ADDR_W.
- HI_BASE, ROWS*LENGTH, base address of the high band. The low band is based at 0.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin frame, clear row index and overflow.
- in_valid  in  1  coefficient pair valid; driven by the lifting stage's result.
- s_in  in  8  low-pass coefficient.
- d_in  in  8  high-pass coefficient.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- busy  out  1  high while streaming or draining; the controller must not enable the lifting stage while busy.
- row_done  out  1  one-cycle pulse after a row is fully written.
- frame_done  out  1  one-cycle pulse after row ROWS-1 is written.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset and initial values
  - On reset, all outputs are 0.
  - State is ST_IDLE; row index r=0, column count j=0; FIFO is empty.
- States: ST_IDLE, ST_WAIT, ST_STREAM, ST_DRAIN.
- ST_IDLE
  - start → r=0, overflow=0, go to ST_WAIT.
  - in_valid is ignored and does not set overflow.
- ST_WAIT
  - in_valid → accept the pair and go to ST_STREAM.
  - start here restarts the frame (r=0).
- Accepting a pair (ST_WAIT or ST_STREAM)
  - d_in is pushed into the FIFO.
  - Next cycle: mem_we=1, mem_addr=r*LENGTH+j, mem_wdata=s_in. Output is registered, latency 1.
  - Then j increments.
- ST_STREAM exit
  - After the LENGTH-th accept, or on the first cycle in_valid=0 with j>0, go to ST_DRAIN.
  - A short row drains only j entries.
- ST_DRAIN
  - One FIFO pop per cycle. Write mem_addr=HI_BASE+r*LENGTH+k, mem_wdata=d, for k=0..j-1.
  - These writes are contiguous, starting the cycle after the last s write, so there is no gap and no collision.
  - FIFO is show-ahead.
- Row end
  - row_done pulses the cycle after the last d write; r increments and j clears.
  - If r was ROWS-1, frame_done pulses in the same cycle, r wraps to 0 and the state goes to ST_IDLE. Otherwise go to ST_WAIT.
- busy: 1 from the first accept through the row_done cycle inclusive.
- Overflow conditions (set overflow=1, sticky until start or reset)
  - in_valid during ST_DRAIN: the pair is dropped, no write.
  - in_valid while j==LENGTH: the pair is dropped.
  - FIFO push when full: cannot occur by construction; the assertion fires in simulation.
- start in ST_STREAM or ST_DRAIN
  - Aborts the row: FIFO flushed, no further writes, r=0, j=0, go to ST_WAIT.
- Reset mid-operation: immediate return to reset values; memory contents are not restored.
- Widths: addresses are computed in ADDR_W bits; r*LENGTH uses a registered running row base (add LENGTH per row), not a multiplier.

Optional Feature:
- Macro: COL_WRITER_WRCOUNT_EN.
- Defined: adds output wr_count [2*ADDR_W-1:0]. It increments on every mem_we, clears on start or reset, and saturates at all-ones.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package essentials gets:
  - ROWS and HI_BASE constants (LENGTH is already there).
  - Writer state enum typedef wr_state_t.
- One sub-module: coeff_fifo. Synchronous show-ahead FIFO, 8-bit wide, depth LENGTH, with push, pop, flush, empty, full and count.

Test Plan:
All scenarios run with LENGTH=4, ROWS=2, HI_BASE=8.
- start, then 4 valid pairs s=10,11,12,13 / d=20,21,22,23 → writes (0,10),(1,11),(2,12),(3,13) on cycles t+1..t+4, then (8,20),(9,21),(10,22),(11,23) on t+5..t+8; row_done at t+9; busy high t..t+9.
- Second row s=30..33 / d=40..43 → addresses 4..7 and 12..15; frame_done and row_done together; state ST_IDLE; r=0.
- Short row, 2 pairs then in_valid=0 → 2 s writes then 2 d writes at 8,9; row_done; no overflow.
- in_valid pulsed during ST_DRAIN → overflow=1, no extra mem_we, drain data intact; next start clears overflow.
- resetn low mid-drain → all outputs 0 immediately; after release, start plus a full row writes from address 0 correctly.
- With COL_WRITER_WRCOUNT_EN: after the full two-row frame, wr_count=16; start clears it to 0.
